// File: rtl/mr1_bus_pkg.sv
// Shared MR1 bus types: request source tags and access-size encodings.
package mr1_bus_pkg;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/mr1_mem_arbiter_if.sv
// Fetch, data and memory request/response signals seen by the MR1 memory arbiter.
interface mr1_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              instr_req_valid;
    logic              instr_req_ready;
    logic [ADDR_W-1:0] instr_req_addr;
    logic              instr_rsp_valid;
    logic [DATA_W-1:0] instr_rsp_data;

    logic              data_req_valid;
    logic              data_req_ready;
    logic              data_req_wr;
    logic [ADDR_W-1:0] data_req_addr;
    logic [1:0]        data_req_size;
    logic [DATA_W-1:0] data_req_data;
    logic              data_rsp_valid;
    logic [DATA_W-1:0] data_rsp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_wr;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [1:0]        mem_req_size;
    logic [DATA_W-1:0] mem_req_data;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;

    logic              rsp_orphan;

    // slave: the arbiter's view
    modport slave (
        input  instr_req_valid, instr_req_addr,
        output instr_req_ready, instr_rsp_valid, instr_rsp_data,
        input  data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
        output data_req_ready, data_rsp_valid, data_rsp_data,
        output mem_req_valid, mem_req_wr, mem_req_addr, mem_req_size, mem_req_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output rsp_orphan
    );

    modport master (
        output instr_req_valid, instr_req_addr,
        input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
        output data_req_valid, data_req_wr, data_req_addr, data_req_size, data_req_data,
        input  data_req_ready, data_rsp_valid, data_rsp_data,
        input  mem_req_valid, mem_req_wr, mem_req_addr, mem_req_size, mem_req_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  rsp_orphan
    );

endinterface

// File: rtl/mr1_tag_fifo.sv
// Source-tag FIFO: remembers which requester issued each outstanding read.
module mr1_tag_fifo
    import mr1_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  src_t                 din,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output src_t                 head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    src_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mr1_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between MR1 fetch and data
// accesses; read responses are routed back in order via a source-tag FIFO.
module mr1_mem_arbiter
    import mr1_bus_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    mr1_mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic              full;
    logic              empty;
    src_t              head;
    logic [CNT_W-1:0]  count;

    logic              elig_i;
    logic              elig_d;
    logic              req_valid;
    logic              accept;
    logic              push;
    logic              pop;
    src_t              gnt;
    logic [ADDR_W-1:0] gnt_addr;

    logic              locked;
    src_t              lock_src;
    src_t              last_grant;
    logic              orphan;

    // Eligibility looks only at the registered count: a same-cycle pop never frees a slot.
    always_comb begin
        elig_i = bus.instr_req_valid && !full;
        elig_d = bus.data_req_valid && (bus.data_req_wr || !full);
        gnt    = SRC_INSTR;
        if (locked)
            gnt = lock_src;
        else if (elig_i && elig_d)
            gnt = (last_grant == SRC_DATA) ? SRC_INSTR : SRC_DATA;
        else if (elig_d)
            gnt = SRC_DATA;
        req_valid = !reset && (locked || elig_i || elig_d);
        gnt_addr  = (gnt == SRC_DATA) ? bus.data_req_addr : bus.instr_req_addr;
    end

    assign accept = req_valid && bus.mem_req_ready;
    assign push   = accept && (gnt == SRC_INSTR || !bus.data_req_wr);
    assign pop    = !reset && bus.mem_rsp_valid && !empty;

    assign bus.mem_req_valid   = req_valid;
    assign bus.mem_req_addr    = gnt_addr;
    assign bus.mem_req_wr      = (gnt == SRC_DATA) && bus.data_req_wr;
    assign bus.mem_req_size    = (gnt == SRC_DATA) ? bus.data_req_size : SIZE_W;
    assign bus.mem_req_data    = (gnt == SRC_DATA) ? bus.data_req_data : DATA_W'(0);
    assign bus.instr_req_ready = accept && (gnt == SRC_INSTR);
    assign bus.data_req_ready  = accept && (gnt == SRC_DATA);

    assign bus.instr_rsp_valid = pop && (head == SRC_INSTR);
    assign bus.data_rsp_valid  = pop && (head == SRC_DATA);
    assign bus.instr_rsp_data  = bus.mem_rsp_data;
    assign bus.data_rsp_data   = bus.mem_rsp_data;
    assign bus.rsp_orphan      = orphan && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            locked     <= 1'b0;
            lock_src   <= SRC_INSTR;
            last_grant <= SRC_DATA;
            orphan     <= 1'b0;
        end else begin
            locked   <= req_valid && !bus.mem_req_ready;
            lock_src <= gnt;
            if (accept) last_grant <= gnt;
            if (bus.mem_rsp_valid && empty) orphan <= 1'b1;
        end
    end

    mr1_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (gnt),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head),
        .count (count)
    );

    // Eligibility gating must keep the tag count within capacity.
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: doc/mr1_mem_arbiter.md
# mr1_mem_arbiter

Shares a single memory port between the MR1 instruction-fetch and data-access request/response interfaces. Sits between the MR1 core and its memory (or the formal/bench memory model): arbitrates requests round-robin, holds a grant until it is accepted, and routes in-order read responses back to the requester that issued them via a small source-tag FIFO.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_OUTSTANDING, 4, max reads in flight; power of two, ≥2

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- instr_req_valid  in  1  fetch request
- instr_req_ready  out  1  fetch request accepted
- instr_req_addr  in  ADDR_W  fetch address
- instr_rsp_valid  out  1  fetch data valid (no backpressure)
- instr_rsp_data  out  DATA_W  fetch data
- data_req_valid  in  1  load/store request
- data_req_ready  out  1  load/store accepted
- data_req_wr  in  1  1 = store (no response), 0 = load
- data_req_addr  in  ADDR_W  address
- data_req_size  in  2  0 byte, 1 half, 2 word
- data_req_data  in  DATA_W  store data
- data_rsp_valid  out  1  load data valid (no backpressure)
- data_rsp_data  out  DATA_W  load data
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_wr  out  1  forwarded wr (0 for fetches)
- mem_req_addr  out  ADDR_W; mem_req_size  out  2 (2 for fetches); mem_req_data  out  DATA_W (0 for fetches)
- mem_rsp_valid  in  1  read response, in request order, reads only
- mem_rsp_data  in  DATA_W  read data
- rsp_orphan  out  1  sticky: response arrived with no read outstanding

## Operation
- Eligibility: a requester is eligible if valid and (store, or tag FIFO not full). Fetches are always reads.
- Arbitration: if one eligible, grant it. If both, grant the one not granted last (last_grant register, reset = DATA so INSTR wins first tie).
- Lock: once mem_req_valid is driven and mem_req_ready is low, grant is held (locked) until the handshake completes, even if the other requester becomes eligible; last_grant updates only on a completed handshake.
- Payload: mem_req_* mux-selected from granted requester; granted requester's ready = mem_req_ready; other ready = 0.
- Tag FIFO: on accepted read, push source (INSTR/DATA); stores push nothing. On mem_rsp_valid with FIFO non-empty, pop; head selects instr_rsp_valid or data_rsp_valid; both rsp_data ports carry mem_rsp_data.
- Full: eligibility uses the registered count only; a pop in the same cycle does not free a slot for a push that cycle.
- Empty: mem_rsp_valid with FIFO empty -> no response forwarded, rsp_orphan set (cleared only by reset).
- Simultaneous push and pop when non-full and non-empty: count unchanged, order preserved.
- Pointers wrap modulo MAX_OUTSTANDING; count is clog2(MAX_OUTSTANDING)+1 bits.

## Timing
- Request path fully combinational: mem_req_* and *_req_ready respond to inputs same cycle; zero added latency.
- Response path combinational: *_rsp_valid same cycle as mem_rsp_valid.
- While reset is high: all ready/valid outputs 0, rsp_orphan 0; next cycle FIFO empty, lock clear, last_grant = DATA.
- Reset mid-operation discards outstanding tags and lock; memory shares the same reset, so no stale responses are expected.
- Requesters must hold valid and payload stable until ready; the arbiter does not register payload.

## Structure
- Package mr1_bus_pkg: src_t enum (SRC_INSTR=0, SRC_DATA=1), size constants (SIZE_B, SIZE_H, SIZE_W).
- Sub-module mr1_tag_fifo: 1-bit-wide synchronous FIFO, depth MAX_OUTSTANDING, push/pop/full/empty/head/count.
- Arbiter, lock and muxing in the top module.

## Test plan
- Fetch alone at 0x100, mem_req_ready=1, response 0xDEADBEEF 2 cycles later -> instr_rsp_valid=1 with 0xDEADBEEF, data_rsp_valid=0.
- Both valid every cycle, mem_req_ready=1, responses each cycle -> grants alternate INSTR, DATA, INSTR…; responses routed in same alternating order.
- Data load granted, mem_req_ready=0 for 3 cycles while fetch valid -> grant stays DATA, mem_req_addr stable, instr_req_ready=0 until handshake.
- MAX_OUTSTANDING=4 loads accepted without responses -> further load and fetch ready=0; store 0x55 to 0x200 still accepted; one response pops, next cycle a load is accepted.
- mem_rsp_valid with no read outstanding -> no rsp_valid pulses, rsp_orphan=1 until reset.
- Reset asserted with 2 reads outstanding -> outputs 0 during reset; after reset count 0, first tie grants INSTR.
